// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: adds two W-bit operands (W = 4*NIBBLES) by passing
// one nibble per cycle through a single NOR-gate 4-bit adder. Two requesters
// share the adder through a fair arbiter. The result is held until taken.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. valid, once raised, stays high with stable payload until the
//   transfer. ready may depend combinationally on valid, but valid never
//   depends on ready.

// One-bit full adder built only from NOR functions.
module nor_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic n_ab;
    logic n_a;
    logic n_b;
    logic xn_ab;
    logic n_xc;
    logic n_x;
    logic n_c;
    logic n_ac;
    logic n_bc;

    // xnor(a, b) from four NORs
    assign n_ab  = ~(a | b);
    assign n_a   = ~(a | n_ab);
    assign n_b   = ~(b | n_ab);
    assign xn_ab = ~(n_a | n_b);

    // s = xnor(xnor(a, b), ci) = a ^ b ^ ci
    assign n_xc  = ~(xn_ab | ci);
    assign n_x   = ~(xn_ab | n_xc);
    assign n_c   = ~(ci | n_xc);
    assign s     = ~(n_x | n_c);

    // co = majority(a, b, ci) = (a|b)&(a|ci)&(b|ci)
    assign n_ac  = ~(a | ci);
    assign n_bc  = ~(b | ci);
    assign co    = ~(n_ab | n_ac | n_bc);
endmodule

// Four-bit ripple adder from NOR full adders.
module four_bit_adder_nor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic c1;
    logic c2;
    logic c3;

    nor_full_adder u_fa0 (.a(a[0]), .b(b[0]), .ci(cin), .s(sum[0]), .co(c1));
    nor_full_adder u_fa1 (.a(a[1]), .b(b[1]), .ci(c1),  .s(sum[1]), .co(c2));
    nor_full_adder u_fa2 (.a(a[2]), .b(b[2]), .ci(c2),  .s(sum[2]), .co(c3));
    nor_full_adder u_fa3 (.a(a[3]), .b(b[3]), .ci(c3),  .s(sum[3]), .co(cout));
endmodule

module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id,
    output logic                   busy,
    output logic [1:0]             dbg_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [W-1:0]    res_sum_q;
    logic            res_cout_q;
    logic            res_id_q;
    logic            res_valid_q;
    logic            busy_q;
    logic            last_served_q;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [W-1:0]    cap_a_d;
    logic [W-1:0]    cap_b_d;
    logic            cap_cin_d;
    logic [KW+1:0]   nib_base;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_sum;
    logic            nib_cout;
    logic            last_pass;

    // Arbiter: a lone valid requester wins; a tie goes to the one not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_served_q;
                grant1 = ~last_served_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Operand selection for the capture on accept
    assign cap_a_d   = grant1 ? req1_a   : req0_a;
    assign cap_b_d   = grant1 ? req1_b   : req0_b;
    assign cap_cin_d = grant1 ? req1_cin : req0_cin;

    // Current nibble slice fed to the shared adder
    assign nib_base  = {k_q, 2'b00};
    assign nib_a     = a_q[nib_base +: 4];
    assign nib_b     = b_q[nib_base +: 4];
    assign k_d       = k_q + KW'(1);
    assign last_pass = (k_q == KW'(NIBBLES - 1));

    four_bit_adder_nor u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Sequencer FSM: capture on accept, one nibble per RUN cycle, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            k_q           <= '0;
            res_sum_q     <= '0;
            res_cout_q    <= 1'b0;
            res_id_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q           <= cap_a_d;
                        b_q           <= cap_b_d;
                        carry_q       <= cap_cin_d;
                        res_id_q      <= grant1;
                        last_served_q <= grant1;
                        k_q           <= '0;
                        // Cleared so partially built sums never show old nibbles
                        res_sum_q     <= '0;
                        res_cout_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sum_q[nib_base +: 4] <= nib_sum;
                    carry_q                  <= nib_cout;
                    if (last_pass) begin
                        k_q         <= '0;
                        res_cout_q  <= nib_cout;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        k_q <= k_d;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
endmodule
